// File: rtl/dcache_writeback_unit.sv
// dcache_writeback_unit: reads a victim line beat by beat from the data array and sends it as a TileLink C-channel message.
module dcache_writeback_unit #(
  parameter int TAG_W = 20,
  parameter int IDX_W = 6,
  parameter int BEATS = 8,
  parameter int BEAT_W = 64,
  localparam int BW = $clog2(BEATS)
) (
  input  logic                clock,
  input  logic                reset,
  output logic                io_req_ready,
  input  logic                io_req_valid,
  input  logic [TAG_W-1:0]    io_req_bits_tag,
  input  logic [IDX_W-1:0]    io_req_bits_idx,
  input  logic [1:0]          io_req_bits_source,
  input  logic [2:0]          io_req_bits_param,
  input  logic                io_req_bits_way_en,
  input  logic                io_req_bits_voluntary,
  output logic                io_data_req_valid,
  input  logic                io_data_req_ready,
  output logic                io_data_req_bits_way_en,
  output logic [IDX_W+BW-1:0] io_data_req_bits_addr,
  input  logic [BEAT_W-1:0]   io_data_resp,
  output logic                io_release_valid,
  input  logic                io_release_ready,
  output logic [2:0]          io_release_bits_opcode,
  output logic [2:0]          io_release_bits_param,
  output logic [1:0]          io_release_bits_source,
  output logic [31:0]         io_release_bits_address,
  output logic [BEAT_W-1:0]   io_release_bits_data,
  input  logic                io_release_ack,
  input  logic [IDX_W-1:0]    io_probe_idx,
  output logic                io_idx_match,
  output logic                io_busy
);
  typedef enum logic [1:0] {IDLE, READ, SEND, WAIT_ACK} state_t;
  state_t state, state_nxt;
  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] idx_q;
  logic [1:0] source_q;
  logic [2:0] param_q;
  logic way_q, vol_q, pend_q;
  logic [BW:0] rd_cnt, wr_cnt;
  logic [BW-1:0] snd_cnt;
  logic [BEAT_W-1:0] buf_q [BEATS];
  logic req_fire, rd_fire, snd_fire;
  assign req_fire = io_req_valid && io_req_ready;
  assign rd_fire = io_data_req_valid && io_data_req_ready;
  assign snd_fire = io_release_valid && io_release_ready;
  always_comb begin
    state_nxt = state;
    io_req_ready = 1'b0;
    io_data_req_valid = 1'b0;
    io_release_valid = 1'b0;
    case (state)
      IDLE: begin
        io_req_ready = 1'b1;
        state_nxt = io_req_valid ? READ : IDLE;
      end
      READ: begin
        io_data_req_valid = rd_cnt < (BW+1)'(BEATS);
        state_nxt = (pend_q && wr_cnt == (BW+1)'(BEATS-1)) ? SEND : READ;
      end
      SEND: begin
        io_release_valid = 1'b1;
        state_nxt = (io_release_ready && snd_cnt == BW'(BEATS-1)) ? (vol_q ? WAIT_ACK : IDLE) : SEND;
      end
      WAIT_ACK: state_nxt = io_release_ack ? IDLE : WAIT_ACK;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      tag_q <= '0;
      idx_q <= '0;
      source_q <= '0;
      param_q <= '0;
      way_q <= 1'b0;
      vol_q <= 1'b0;
      pend_q <= 1'b0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      snd_cnt <= '0;
    end else begin
      state <= state_nxt;
      pend_q <= rd_fire;
      if (req_fire) begin
        tag_q <= io_req_bits_tag;
        idx_q <= io_req_bits_idx;
        source_q <= io_req_bits_source;
        param_q <= io_req_bits_param;
        way_q <= io_req_bits_way_en;
        vol_q <= io_req_bits_voluntary;
        rd_cnt <= '0;
        wr_cnt <= '0;
        snd_cnt <= '0;
      end else begin
        if (rd_fire) rd_cnt <= rd_cnt + 1'b1;
        if (pend_q) wr_cnt <= wr_cnt + 1'b1;
        if (snd_fire) snd_cnt <= snd_cnt + 1'b1;
      end
    end
  end
  // Response arrives exactly one cycle after each read fire; pend_q marks it.
  always_ff @(posedge clock) begin
    if (pend_q) buf_q[wr_cnt[BW-1:0]] <= io_data_resp;
  end
  assign io_data_req_bits_way_en = way_q;
  assign io_data_req_bits_addr = {idx_q, rd_cnt[BW-1:0]};
  assign io_release_bits_opcode = vol_q ? 3'd7 : 3'd5;
  assign io_release_bits_param = param_q;
  assign io_release_bits_source = source_q;
  assign io_release_bits_address = 32'({tag_q, idx_q, 6'b0});
  assign io_release_bits_data = buf_q[snd_cnt];
  assign io_busy = state != IDLE;
  assign io_idx_match = io_busy && idx_q == io_probe_idx;
endmodule

// File: tb/tb_dcache_writeback_unit.sv
// tb_dcache_writeback_unit: directed checks of the writeback unit with a one-cycle-latency data array model.
module tb_dcache_writeback_unit;
  logic clock = 1'b0;
  logic reset;
  logic io_req_ready, io_req_valid;
  logic [19:0] io_req_bits_tag;
  logic [5:0] io_req_bits_idx;
  logic [1:0] io_req_bits_source;
  logic [2:0] io_req_bits_param;
  logic io_req_bits_way_en, io_req_bits_voluntary;
  logic io_data_req_valid, io_data_req_ready, io_data_req_bits_way_en;
  logic [8:0] io_data_req_bits_addr;
  logic [63:0] io_data_resp;
  logic io_release_valid, io_release_ready;
  logic [2:0] io_release_bits_opcode, io_release_bits_param;
  logic [1:0] io_release_bits_source;
  logic [31:0] io_release_bits_address;
  logic [63:0] io_release_bits_data;
  logic io_release_ack;
  logic [5:0] io_probe_idx;
  logic io_idx_match, io_busy;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_fire = 0;
  int issue_cnt [8];
  logic [63:0] data_base;
  dcache_writeback_unit dut (
    .clock(clock), .reset(reset),
    .io_req_ready(io_req_ready), .io_req_valid(io_req_valid),
    .io_req_bits_tag(io_req_bits_tag), .io_req_bits_idx(io_req_bits_idx),
    .io_req_bits_source(io_req_bits_source), .io_req_bits_param(io_req_bits_param),
    .io_req_bits_way_en(io_req_bits_way_en), .io_req_bits_voluntary(io_req_bits_voluntary),
    .io_data_req_valid(io_data_req_valid), .io_data_req_ready(io_data_req_ready),
    .io_data_req_bits_way_en(io_data_req_bits_way_en), .io_data_req_bits_addr(io_data_req_bits_addr),
    .io_data_resp(io_data_resp),
    .io_release_valid(io_release_valid), .io_release_ready(io_release_ready),
    .io_release_bits_opcode(io_release_bits_opcode), .io_release_bits_param(io_release_bits_param),
    .io_release_bits_source(io_release_bits_source), .io_release_bits_address(io_release_bits_address),
    .io_release_bits_data(io_release_bits_data), .io_release_ack(io_release_ack),
    .io_probe_idx(io_probe_idx), .io_idx_match(io_idx_match), .io_busy(io_busy)
  );
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (io_data_req_valid && io_data_req_ready) begin
      issue_cnt[io_data_req_bits_addr[2:0]]++;
      last_fire = cyc;
    end
    cyc++;
  end
  always @(posedge clock)
    io_data_resp <= (io_data_req_valid && io_data_req_ready) ? data_base + 64'(io_data_req_bits_addr[2:0]) : 64'h0;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send_req(input logic [19:0] tag, input logic [5:0] idx, input logic [1:0] src, input logic [2:0] prm, input logic vol);
    io_req_bits_tag = tag;
    io_req_bits_idx = idx;
    io_req_bits_source = src;
    io_req_bits_param = prm;
    io_req_bits_way_en = 1'b1;
    io_req_bits_voluntary = vol;
    io_req_valid = 1'b1;
    chk("req_ready_idle", io_req_ready, 1'b1);
    tick();
    io_req_valid = 1'b0;
  endtask
  task automatic expect_msg(input logic [63:0] base, input logic [2:0] op, input logic [2:0] prm, input logic [1:0] src, input logic [31:0] addr);
    for (int i = 0; i < 40 && !io_release_valid; i++) tick();
    for (int n = 0; n < 8; n++) begin
      chk("rel_valid", io_release_valid, 1'b1);
      chk("rel_data", io_release_bits_data, base + 64'(n));
      if (n == 0) begin
        chk("rel_opcode", io_release_bits_opcode, op);
        chk("rel_param", io_release_bits_param, prm);
        chk("rel_source", io_release_bits_source, src);
        chk("rel_address", io_release_bits_address, addr);
      end
      tick();
    end
  endtask
  initial begin
    logic [8:0] saved_addr;
    logic stalled;
    int nbeat, nstall;
    reset = 1'b0;
    io_req_valid = 1'b0;
    io_req_bits_tag = '0;
    io_req_bits_idx = '0;
    io_req_bits_source = '0;
    io_req_bits_param = '0;
    io_req_bits_way_en = 1'b0;
    io_req_bits_voluntary = 1'b0;
    io_data_req_ready = 1'b1;
    io_release_ready = 1'b1;
    io_release_ack = 1'b0;
    io_probe_idx = '0;
    data_base = '0;
    foreach (issue_cnt[i]) issue_cnt[i] = 0;
    #12;
    chk("rst_req_ready", io_req_ready, 1'b1);
    chk("rst_data_req_valid", io_data_req_valid, 1'b0);
    chk("rst_release_valid", io_release_valid, 1'b0);
    chk("rst_busy", io_busy, 1'b0);
    chk("rst_idx_match", io_idx_match, 1'b0);
    reset = 1'b1;
    tick();
    // Voluntary eviction with exact cycle timing
    data_base = 64'h1111_0000_0000_0000;
    send_req(20'hABCDE, 6'h15, 2'd1, 3'd1, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      chk("v_rd_valid", io_data_req_valid, 1'b1);
      chk("v_rd_addr", io_data_req_bits_addr, {6'h15, 3'(c - 1)});
      tick();
    end
    chk("v_c9_rd_valid", io_data_req_valid, 1'b0);
    chk("v_c9_rel_valid", io_release_valid, 1'b0);
    tick();
    chk("v_c10_rel_valid", io_release_valid, 1'b1);
    expect_msg(64'h1111_0000_0000_0000, 3'd7, 3'd1, 2'd1, 32'hABCDE540);
    chk("v_c18_busy", io_busy, 1'b1);
    chk("v_c18_rel_valid", io_release_valid, 1'b0);
    chk("v_c18_req_ready", io_req_ready, 1'b0);
    for (int c = 18; c < 25; c++) tick();
    chk("v_c25_busy", io_busy, 1'b1);
    io_release_ack = 1'b1;
    tick();
    io_release_ack = 1'b0;
    chk("v_c26_busy", io_busy, 1'b0);
    chk("v_c26_req_ready", io_req_ready, 1'b1);
    // Probe response, then a spurious ack
    data_base = 64'h2222_0000_0000_0000;
    send_req(20'h12345, 6'h2A, 2'd2, 3'd2, 1'b0);
    for (int c = 1; c <= 9; c++) tick();
    chk("p_c10_rel_valid", io_release_valid, 1'b1);
    expect_msg(64'h2222_0000_0000_0000, 3'd5, 3'd2, 2'd2, 32'h12345A80);
    chk("p_c18_busy", io_busy, 1'b0);
    chk("p_c18_req_ready", io_req_ready, 1'b1);
    io_release_ack = 1'b1;
    tick();
    io_release_ack = 1'b0;
    chk("p_ack_busy", io_busy, 1'b0);
    chk("p_ack_rel_valid", io_release_valid, 1'b0);
    // Data-array backpressure on alternate cycles
    data_base = 64'h3333_0000_0000_0000;
    foreach (issue_cnt[i]) issue_cnt[i] = 0;
    send_req(20'h00F0F, 6'h07, 2'd3, 3'd0, 1'b0);
    io_data_req_ready = 1'b0;
    for (int i = 0; i < 40 && !io_release_valid; i++) begin
      stalled = io_data_req_valid && !io_data_req_ready;
      saved_addr = io_data_req_bits_addr;
      tick();
      if (stalled) begin
        chk("bp_rd_valid_held", io_data_req_valid, 1'b1);
        chk("bp_rd_addr_held", io_data_req_bits_addr, saved_addr);
      end
      io_data_req_ready = !io_data_req_ready;
    end
    io_data_req_ready = 1'b1;
    chk("bp_send_started", io_release_valid, 1'b1);
    chk("bp_send_latency", 64'(cyc), 64'(last_fire + 2));
    for (int a = 0; a < 8; a++) chk("bp_issue_once", 64'(issue_cnt[a]), 64'd1);
    expect_msg(64'h3333_0000_0000_0000, 3'd5, 3'd0, 2'd3, 32'h00F0F1C0);
    // C-channel backpressure during beat 4
    data_base = 64'h4444_0000_0000_0000;
    send_req(20'h54321, 6'h3F, 2'd0, 3'd1, 1'b0);
    nbeat = 0;
    nstall = 0;
    for (int i = 0; i < 40 && nbeat < 8; i++) begin
      io_release_ready = !(nbeat == 4 && nstall < 3);
      if (io_release_valid && !io_release_ready) begin
        nstall++;
        chk("cbp_data_held", io_release_bits_data, 64'h4444_0000_0000_0004);
        chk("cbp_addr_held", io_release_bits_address, 32'h54321FC0);
        chk("cbp_opcode_held", io_release_bits_opcode, 3'd5);
      end
      if (io_release_valid && io_release_ready) begin
        chk("cbp_beat", io_release_bits_data, 64'h4444_0000_0000_0000 + 64'(nbeat));
        nbeat++;
      end
      tick();
    end
    io_release_ready = 1'b1;
    chk("cbp_beats", 64'(nbeat), 64'd8);
    chk("cbp_stalls", 64'(nstall), 64'd3);
    chk("cbp_idle", io_busy, 1'b0);
    // Back-to-back requests with set-match tracking
    data_base = 64'h5555_0000_0000_0000;
    io_probe_idx = 6'h33;
    send_req(20'h0AAAA, 6'h33, 2'd1, 3'd0, 1'b0);
    io_req_bits_tag = 20'h0BBBB;
    io_req_bits_idx = 6'h0C;
    io_req_valid = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      chk("b2b_req_ready_busy", io_req_ready, 1'b0);
      chk("b2b_idx_match_busy", io_idx_match, 1'b1);
      tick();
    end
    chk("b2b_c18_req_ready", io_req_ready, 1'b1);
    chk("b2b_c18_idx_match", io_idx_match, 1'b0);
    tick();
    io_req_valid = 1'b0;
    chk("b2b_second_busy", io_busy, 1'b1);
    chk("b2b_second_no_match", io_idx_match, 1'b0);
    io_probe_idx = 6'h0C;
    #1;
    chk("b2b_second_match", io_idx_match, 1'b1);
    for (int i = 0; i < 40 && io_busy; i++) tick();
    chk("b2b_second_done", io_busy, 1'b0);
    chk("b2b_idle_no_match", io_idx_match, 1'b0);
    // Reset during beat 3 of a voluntary release
    data_base = 64'h6666_0000_0000_0000;
    send_req(20'h0BEEF, 6'h11, 2'd1, 3'd0, 1'b1);
    for (int c = 1; c <= 12; c++) tick();
    chk("rst_mid_valid", io_release_valid, 1'b1);
    chk("rst_mid_beat3", io_release_bits_data, 64'h6666_0000_0000_0003);
    reset = 1'b0;
    #1;
    chk("rst_async_rel_valid", io_release_valid, 1'b0);
    chk("rst_async_rd_valid", io_data_req_valid, 1'b0);
    chk("rst_async_busy", io_busy, 1'b0);
    chk("rst_async_req_ready", io_req_ready, 1'b1);
    #2;
    reset = 1'b1;
    tick();
    chk("rst_after_req_ready", io_req_ready, 1'b1);
    data_base = 64'h7777_0000_0000_0000;
    send_req(20'h0CAFE, 6'h22, 2'd2, 3'd3, 1'b0);
    chk("rst_fresh_addr0", io_data_req_bits_addr, {6'h22, 3'd0});
    for (int c = 1; c <= 9; c++) tick();
    chk("rst_fresh_send", io_release_valid, 1'b1);
    expect_msg(64'h7777_0000_0000_0000, 3'd5, 3'd3, 2'd2, 32'h0CAFE880);
    chk("rst_fresh_idle", io_busy, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
